// File: rtl/ds1302_sched_if.sv
// Purpose: bundles the set-request, base-module and time-publication signals of ds1302_sched.
// Latency: none; plain wires.
// Backpressure: none; the base module paces transactions through iDone.
interface ds1302_sched_if;
    logic        iSet;        // one-cycle set request
    logic [23:0] iSetTime;    // BCD {hh,mm,ss}, sampled with iSet
    logic        oSetAck;     // set request completed or rejected
    logic        oSetErr;     // with oSetAck: 1 = rejected / failed
    logic [7:0]  oCall;       // one-hot transaction request to the base module
    logic        iDone;       // base-module completion pulse
    logic [7:0]  oData;       // write data to the base module
    logic [7:0]  iData;       // read data from the base module
    logic [23:0] oTime;       // last coherent BCD time
    logic        oTimeValid;  // pulse when oTime updates
    logic        oErr;        // sticky timeout flag
    logic        oBusy;       // transaction in flight

    modport master (
        input  iSet, iSetTime, iDone, iData,
        output oSetAck, oSetErr, oCall, oData, oTime, oTimeValid, oErr, oBusy
    );

    modport slave (
        output iSet, iSetTime, iDone, iData,
        input  oSetAck, oSetErr, oCall, oData, oTime, oTimeValid, oErr, oBusy
    );
endinterface

// File: rtl/ds1302_sched.sv
// Purpose: sequences DS1302 base-module transactions: init write, periodic time read-back, host time set.
// Latency: one transaction per oCall/iDone handshake plus one idle cycle; oTime updates one cycle after the hour read.
// Backpressure: each call is held until iDone or TIMEOUT cycles; set requests queue one deep and run only from WAIT.
// Ports: CLOCK, RST (sync, active-high), bus (master modport: set request/ack, base-module call/done/data, time out).
module ds1302_sched #(
    parameter logic [23:0] INIT_TIME = 24'h215950,
    parameter int unsigned POLL_DIV  = 5_000_000,
    parameter int unsigned TIMEOUT   = 65_535
) (
    input  logic           CLOCK,
    input  logic           RST,
    ds1302_sched_if.master bus
);
    typedef enum logic [3:0] {
        INIT_WP, INIT_HR, INIT_MIN, INIT_SEC, WAIT,
        RD_SEC, RD_MIN, RD_HR, PUBLISH,
        SET_WP, SET_HR, SET_MIN, SET_SEC
    } state_t;

    state_t      state, succ_state, fail_state;
    logic [7:0]  call, dat, call_code, call_data;
    logic [31:0] poll_cnt, timer;
    logic [7:0]  sec_h, min_h, hr_h;
    logic [23:0] time_q, pend_time, set_time;
    logic        pend, time_vld, set_ack, set_err, err_flag;
    logic        ack_owe, ack_owe_err;
    logic        set_state, done_now, tmo_now, fsm_ack, rej;

    function automatic logic bcd_ok(input logic [23:0] t);
        bcd_ok = (t[3:0] <= 4'd9) && (t[11:8] <= 4'd9) && (t[19:16] <= 4'd9) &&
                 (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
    endfunction

    // Per-state call code, write data and where to go on success or timeout.
    always_comb begin
        call_code  = 8'h00;
        call_data  = 8'h00;
        succ_state = WAIT;
        fail_state = WAIT;
        case (state)
            INIT_WP:  begin call_code = 8'h80; succ_state = INIT_HR;  fail_state = INIT_HR;  end
            INIT_HR:  begin call_code = 8'h40; call_data = INIT_TIME[23:16];
                            succ_state = INIT_MIN; fail_state = INIT_MIN; end
            INIT_MIN: begin call_code = 8'h20; call_data = INIT_TIME[15:8];
                            succ_state = INIT_SEC; fail_state = INIT_SEC; end
            INIT_SEC: begin call_code = 8'h10; call_data = {1'b0, INIT_TIME[6:0]}; end
            RD_SEC:   begin call_code = 8'h01; succ_state = RD_MIN;  end
            RD_MIN:   begin call_code = 8'h02; succ_state = RD_HR;   end
            RD_HR:    begin call_code = 8'h04; succ_state = PUBLISH; end
            SET_WP:   begin call_code = 8'h80; succ_state = SET_HR;  end
            SET_HR:   begin call_code = 8'h40; call_data = set_time[23:16]; succ_state = SET_MIN; end
            SET_MIN:  begin call_code = 8'h20; call_data = set_time[15:8];  succ_state = SET_SEC; end
            SET_SEC:  begin call_code = 8'h10; call_data = set_time[7:0] & 8'h7F; end
            default:  ;
        endcase
    end

    assign set_state = (state == SET_WP) || (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
    assign done_now  = (call != 8'h00) && bus.iDone;
    assign tmo_now   = (call != 8'h00) && !bus.iDone && (timer == TIMEOUT - 1);
    // A set finishes (ack) on the last write's iDone or on a timeout in any set step.
    assign fsm_ack   = set_state && ((done_now && state == SET_SEC) || tmo_now);
    assign rej       = bus.iSet && !bcd_ok(bus.iSetTime);

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state       <= INIT_WP;
            call        <= 8'h00;
            dat         <= 8'h00;
            poll_cnt    <= 32'd0;
            timer       <= 32'd0;
            sec_h       <= 8'h00;
            min_h       <= 8'h00;
            hr_h        <= 8'h00;
            time_q      <= 24'h0;
            time_vld    <= 1'b0;
            set_ack     <= 1'b0;
            set_err     <= 1'b0;
            err_flag    <= 1'b0;
            pend        <= 1'b0;
            pend_time   <= 24'h0;
            set_time    <= 24'h0;
            ack_owe     <= 1'b0;
            ack_owe_err <= 1'b0;
        end else begin
            time_vld <= 1'b0;
            case (state)
                WAIT: begin
                    if (pend) begin
                        // Snapshot so a later request cannot alter a set in progress.
                        state     <= SET_WP;
                        set_time  <= pend_time;
                        pend      <= 1'b0;
                        poll_cnt  <= 32'd0;
                    end else if (poll_cnt == POLL_DIV - 1) begin
                        state    <= RD_SEC;
                        poll_cnt <= 32'd0;
                    end else begin
                        poll_cnt <= poll_cnt + 32'd1;
                    end
                end
                PUBLISH: begin
                    time_q   <= {hr_h, min_h, sec_h};
                    time_vld <= 1'b1;
                    state    <= WAIT;
                end
                default: begin
                    if (call == 8'h00) begin
                        // Entering a step always finds oCall low, which gives the idle cycle.
                        if (call_code == 8'h00) begin
                            state <= INIT_WP;
                        end
                        call  <= call_code;
                        dat   <= call_data;
                        timer <= 32'd0;
                    end else if (done_now) begin
                        call  <= 8'h00;
                        dat   <= 8'h00;
                        state <= succ_state;
                        if (state == RD_SEC) sec_h <= bus.iData & 8'h7F;
                        if (state == RD_MIN) min_h <= bus.iData & 8'h7F;
                        if (state == RD_HR)  hr_h  <= bus.iData & 8'h3F;
                    end else if (tmo_now) begin
                        call     <= 8'h00;
                        dat      <= 8'h00;
                        err_flag <= 1'b1;
                        state    <= fail_state;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
            endcase

            // After the FSM so a request arriving as WAIT consumes the old one is kept.
            if (bus.iSet && !rej) begin
                pend      <= 1'b1;
                pend_time <= bus.iSetTime;
            end

            // A rejection and a set completion in the same cycle: reject now, completion next.
            set_ack <= 1'b0;
            set_err <= 1'b0;
            if (rej) begin
                set_ack <= 1'b1;
                set_err <= 1'b1;
                if (fsm_ack) begin
                    ack_owe     <= 1'b1;
                    ack_owe_err <= tmo_now;
                end
            end else if (fsm_ack) begin
                set_ack <= 1'b1;
                set_err <= tmo_now;
            end else if (ack_owe) begin
                set_ack <= 1'b1;
                set_err <= ack_owe_err;
                ack_owe <= 1'b0;
            end
        end
    end

    assign bus.oCall      = call;
    assign bus.oData      = dat;
    assign bus.oTime      = time_q;
    assign bus.oTimeValid = time_vld;
    assign bus.oSetAck    = set_ack;
    assign bus.oSetErr    = set_err;
    assign bus.oErr       = err_flag;
    assign bus.oBusy      = (call != 8'h00);
endmodule

// File: tb/tb_ds1302_sched.sv
// Purpose: randomized scoreboard bench for ds1302_sched against a behavioural base-module model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ds1302_sched;
    localparam int unsigned POLL = 100;
    localparam int unsigned TMO  = 50;
    localparam logic [23:0] INIT = 24'h215950;

    localparam logic [1:0] EV_CALL = 2'd0;
    localparam logic [1:0] EV_PUB  = 2'd1;
    localparam logic [1:0] EV_ACK  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] val;   // call: {8'h00, code, data}; pub: time; ack: err
        logic [7:0]  dur;   // required call length in cycles, 0 = any
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ds1302_sched_if bus();

    ds1302_sched #(.INIT_TIME(INIT), .POLL_DIV(POLL), .TIMEOUT(TMO)) dut (
        .CLOCK (clk),
        .RST   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         lat_fixed = 40;
    logic [7:0] withhold = 8'h00;
    logic [7:0] resp_sec = 8'h00, resp_min = 8'h00, resp_hr = 8'h00;

    function automatic ev_t mk_ev(logic [1:0] k, logic [23:0] v, logic [7:0] d);
        ev_t e;
        e.kind = k; e.val = v; e.dur = d;
        return e;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit model_valid(logic [23:0] t);
        logic [7:0] f [3];
        int lim [3];
        f[0] = t[23:16]; f[1] = t[15:8]; f[2] = t[7:0];
        lim[0] = 24; lim[1] = 60; lim[2] = 60;
        for (int i = 0; i < 3; i++) begin
            if (f[i][3:0] > 4'd9 || f[i][7:4] > 4'd9) return 1'b0;
            if (int'(f[i][7:4]) * 10 + int'(f[i][3:0]) >= lim[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [23:0] rand_valid();
        return {to_bcd(int'($urandom_range(23))), to_bcd(int'($urandom_range(59))),
                to_bcd(int'($urandom_range(59)))};
    endfunction

    function automatic logic [23:0] rand_invalid();
        logic [23:0] t;
        do t = 24'($urandom); while (model_valid(t));
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic emit(logic [1:0] kind, logic [23:0] val, int dur);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d val=%h required=none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val || (e.dur != 8'd0 && int'(e.dur) != dur)) begin
                errors++;
                $display("FAIL event actual kind=%0d val=%h dur=%0d required kind=%0d val=%h dur=%0d",
                         kind, val, dur, e.kind, e.val, e.dur);
            end
        end
    endtask

    // Base-module model: answers each new call after a latency, with the configured read data.
    initial begin
        int         cnt;
        logic [7:0] seen;
        logic       fired;
        bus.iDone = 1'b0; bus.iData = 8'h00;
        cnt = 0; seen = 8'h00; fired = 1'b0;
        forever begin
            @(negedge clk);
            bus.iDone = 1'b0;
            if (bus.oCall == 8'h00) begin
                seen = 8'h00;
                if ($urandom_range(15) == 0) bus.iDone = 1'b1;  // stray pulse must be ignored
            end else if (bus.oCall != seen) begin
                seen  = bus.oCall;
                fired = 1'b0;
                cnt   = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(30, 1));
            end else if (!fired && withhold != seen) begin
                cnt--;
                if (cnt == 0) begin
                    fired     = 1'b1;
                    bus.iDone = 1'b1;
                    case (seen)
                        8'h01:   bus.iData = resp_sec;
                        8'h02:   bus.iData = resp_min;
                        8'h04:   bus.iData = resp_hr;
                        default: bus.iData = 8'($urandom);
                    endcase
                end
            end
        end
    end

    // Monitor: turns DUT activity into events and checks per-cycle protocol rules.
    initial begin
        logic [7:0] prev, code, data;
        int         dur, cyc, last_pub;
        logic       gap_chk;
        prev = 8'h00; code = 8'h00; data = 8'h00;
        dur = 0; cyc = 0; last_pub = 0; gap_chk = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("busy", 32'(bus.oBusy), 32'(bus.oCall != 8'h00));
            if (bus.oCall != 8'h00) begin
                chk("onehot", $countones(bus.oCall), 1);
                if (prev == 8'h00) begin
                    code = bus.oCall; data = bus.oData; dur = 1;
                    if (gap_chk && code == 8'h01) chk("poll_period", cyc - last_pub, int'(POLL) + 1);
                    gap_chk = 1'b0;
                end else if (bus.oCall == prev) begin
                    dur++;
                    chk("data_hold", bus.oData, data);
                end else begin
                    chk("idle_gap", bus.oCall, prev);
                end
            end else if (prev != 8'h00) begin
                emit(EV_CALL, {8'h00, code, data}, dur);
            end
            if (bus.oTimeValid) begin
                emit(EV_PUB, bus.oTime, 0);
                last_pub = cyc;
                gap_chk  = 1'b1;
            end
            if (bus.oSetAck) emit(EV_ACK, {23'd0, bus.oSetErr}, 0);
            if (rst) gap_chk = 1'b0;
            prev = bus.oCall;
        end
    end

    task automatic push_call(logic [7:0] code, logic [7:0] data, logic [7:0] dur);
        exp_q.push_back(mk_ev(EV_CALL, {8'h00, code, data}, dur));
    endtask

    task automatic push_init();
        push_call(8'h80, 8'h00, 8'd0);
        push_call(8'h40, INIT[23:16], 8'd0);
        push_call(8'h20, INIT[15:8], 8'd0);
        push_call(8'h10, INIT[7:0] & 8'h7F, 8'd0);
    endtask

    task automatic push_sweep(logic [7:0] s, logic [7:0] m, logic [7:0] h);
        resp_sec = s; resp_min = m; resp_hr = h;
        push_call(8'h01, 8'h00, 8'd0);
        push_call(8'h02, 8'h00, 8'd0);
        push_call(8'h04, 8'h00, 8'd0);
        exp_q.push_back(mk_ev(EV_PUB, {h & 8'h3F, m & 8'h7F, s & 8'h7F}, 8'd0));
    endtask

    task automatic push_set(logic [23:0] t);
        push_call(8'h80, 8'h00, 8'd0);
        push_call(8'h40, t[23:16], 8'd0);
        push_call(8'h20, t[15:8], 8'd0);
        push_call(8'h10, t[7:0] & 8'h7F, 8'd0);
        exp_q.push_back(mk_ev(EV_ACK, 24'd0, 8'd0));
    endtask

    task automatic pulse_set(logic [23:0] t);
        bus.iSet = 1'b1; bus.iSetTime = t;
        @(negedge clk);
        bus.iSet = 1'b0;
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s actual_left=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_call(logic [7:0] code, int budget);
        int n = 0;
        while (bus.oCall != code && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_call", bus.oCall, code);
    endtask

    task automatic reject_test(logic [23:0] t);
        exp_q.push_back(mk_ev(EV_ACK, 24'd1, 8'd0));
        pulse_set(t);
        chk("rej_ack", {bus.oSetAck, bus.oSetErr}, 2'b11);
        repeat (3) begin
            chk("rej_nocall", bus.oCall, 8'h00);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_call", bus.oCall, 8'h00);
        chk("rst_data", bus.oData, 8'h00);
        chk("rst_time", bus.oTime, 24'h0);
        chk("rst_tvalid", bus.oTimeValid, 1'b0);
        chk("rst_ack", bus.oSetAck, 1'b0);
        chk("rst_seterr", bus.oSetErr, 1'b0);
        chk("rst_err", bus.oErr, 1'b0);
        chk("rst_busy", bus.oBusy, 1'b0);
    endtask

    initial begin
        logic [23:0] a, b;
        bus.iSet = 1'b0; bus.iSetTime = 24'h0;
        repeat (3) @(negedge clk);
        check_reset_state();

        // Power-up init with a slow base module.
        push_init();
        rst = 1'b0;
        wait_drain("init", 400);
        chk("err_after_init", bus.oErr, 1'b0);
        lat_fixed = 0;

        // First sweep with control bits set in the raw read data.
        push_sweep(8'hD9, 8'h59, 8'hA3);
        wait_drain("sweep_fixed", 500);
        chk("time_hold", bus.oTime, 24'h235959);

        // Invalid set requests are rejected immediately and start nothing.
        reject_test(24'h246000);
        for (int i = 0; i < 3; i++) reject_test(rand_invalid());

        for (int i = 0; i < 4; i++) begin
            push_sweep(8'($urandom), 8'($urandom), 8'($urandom));
            wait_drain("sweep_rand", 500);
        end

        // Set arriving during the minute read waits for the sweep to publish.
        push_sweep(8'h12, 8'h34, 8'h05);
        push_set(24'h123000);
        wait_call(8'h02, 400);
        pulse_set(24'h123000);
        wait_drain("set_rdmin", 700);

        // Two requests during one sweep: only the later one is written, with one ack.
        a = rand_valid();
        b = rand_valid();
        push_sweep(8'($urandom), 8'($urandom), 8'($urandom));
        push_set(b);
        wait_call(8'h01, 400);
        pulse_set(a);
        @(negedge clk);
        pulse_set(b);
        wait_drain("set_overwrite", 700);

        // Sets issued straight from WAIT.
        for (int i = 0; i < 2; i++) begin
            a = rand_valid();
            push_set(a);
            pulse_set(a);
            wait_drain("set_wait", 400);
        end

        // Base module never answers the minute read: sweep aborts after TMO cycles.
        withhold = 8'h02;
        push_call(8'h01, 8'h00, 8'd0);
        push_call(8'h02, 8'h00, 8'(TMO));
        wait_drain("timeout", 500);
        repeat (5) @(negedge clk);
        chk("err_sticky", bus.oErr, 1'b1);
        withhold = 8'h00;
        push_sweep(8'($urandom), 8'($urandom), 8'($urandom));
        wait_drain("after_timeout", 500);
        chk("err_still", bus.oErr, 1'b1);

        // Reset in the middle of a second read restarts init.
        push_call(8'h01, 8'h00, 8'd0);
        wait_call(8'h01, 400);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        repeat (2) @(negedge clk);
        push_init();
        rst = 1'b0;
        wait_drain("reinit", 400);
        push_sweep(8'($urandom), 8'($urandom), 8'($urandom));
        wait_drain("final_sweep", 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
